// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared writeback types, source indices and helpers
package wb_arb_pkg;

  localparam int XLEN       = 32;
  localparam int WB_NUM_SRC = 5;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_MAC = 3;
  localparam int SRC_LSU = 4;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic [XLEN-1:0] tag;
    logic [31:0]     instr;
  } wb_entry_t;

  // One-hot register mask for a destination register number
  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_arb_if.sv
// rtl/wb_arb_if.sv - writeback source and register-file port bundle
interface wb_arb_if
  import wb_arb_pkg::*;
#(
  parameter int NSRC = WB_NUM_SRC
);

  logic      [NSRC-1:0] src_valid;
  wb_entry_t [NSRC-1:0] src_entry;
  logic      [NSRC-1:0] src_full;
  logic                 rf_wr_en;
  logic      [4:0]      rf_wr_addr;
  logic      [XLEN-1:0] rf_wr_data;
  logic      [XLEN-1:0] instr_tag_out;
  logic      [31:0]     instr_out;
  logic      [31:0]     pending_rd_mask;

  // Arbiter side
  modport slave (
    input  src_valid, src_entry,
    output src_full, rf_wr_en, rf_wr_addr, rf_wr_data,
           instr_tag_out, instr_out, pending_rd_mask
  );

  // Execution units / register file side
  modport master (
    output src_valid, src_entry,
    input  src_full, rf_wr_en, rf_wr_addr, rf_wr_data,
           instr_tag_out, instr_out, pending_rd_mask
  );

endinterface

// File: rtl/wb_arb_rr_arb.sv
// rtl/wb_arb_rr_arb.sv - round-robin one-hot grant with internal priority pointer
module rr_arb #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic          any;
  int            win;
  int            idx;

  // Scan requests starting at the pointer; first hit wins
  always_comb begin
    grant = '0;
    any   = 1'b0;
    win   = 0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
        win        = idx;
      end
    end
  end

  // Pointer moves just past the winner; holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (any) begin
      ptr_q <= (win + 1 >= N) ? '0 : PW'(win + 1);
    end
  end

endmodule

// File: rtl/wb_arb.sv
// rtl/wb_arb.sv - writeback arbiter: per-source one-entry buffers into a single RF write port (optional WB_RETIRE_CNT_EN)
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int NSRC = WB_NUM_SRC
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arb_if.slave     bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retire_cnt
`endif
);

  logic      [NSRC-1:0] buf_valid;
  wb_entry_t            buf_entry [NSRC];
  logic      [NSRC-1:0] grant;
  logic      [NSRC-1:0] full;
  logic      [NSRC-1:0] load;
  wb_entry_t            sel;
  logic      [31:0]     mask;

  rr_arb #(.N(NSRC)) u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (buf_valid),
    .grant (grant)
  );

  // A buffer being drained this cycle can take a new entry at the same edge
  assign full         = buf_valid & ~grant;
  assign bus.src_full = full;

  // Accept only when not full; rd=0 writes are architecturally dead, drop them
  always_comb begin
    load = '0;
    for (int i = 0; i < NSRC; i++) begin
      load[i] = bus.src_valid[i] & ~full[i] & (bus.src_entry[i].rd != 5'd0);
    end
  end

  // Buffer occupancy: load wins over grant-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (load[i]) begin
          buf_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Buffer payload; qualified by buf_valid so it needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (load[i]) begin
        buf_entry[i] <= bus.src_entry[i];
      end
    end
  end

  // Mux out the granted entry; zero when nothing is granted
  always_comb begin
    sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        sel = buf_entry[i];
      end
    end
  end

  // Hazard mask covers every occupied buffer, including the one retiring now
  always_comb begin
    mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (buf_valid[i]) begin
        mask = mask | rd_onehot(buf_entry[i].rd);
      end
    end
  end

  assign bus.rf_wr_en        = |grant;
  assign bus.rf_wr_addr      = sel.rd;
  assign bus.rf_wr_data      = sel.data;
  assign bus.instr_tag_out   = sel.tag;
  assign bus.instr_out       = sel.instr;
  assign bus.pending_rd_mask = mask;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_q;

  // Free-running count of register-file writes, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (|grant) begin
      retire_q <= retire_q + 64'd1;
    end
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_wb_arb.sv
// tb/tb_wb_arb.sv - directed self-checking bench for wb_arb
module tb_wb_arb;
  import wb_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  wb_arb_if #(.NSRC(WB_NUM_SRC)) bus ();

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  wb_arb #(.NSRC(WB_NUM_SRC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic wb_entry_t mk(input logic [31:0] data, input logic [4:0] rd,
                                   input logic [31:0] tag, input logic [31:0] instr);
    wb_entry_t e;
    e.data  = data;
    e.rd    = rd;
    e.tag   = tag;
    e.instr = instr;
    return e;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_full"},  64'(bus.src_full), 64'h0);
    check({tag, "_en"},    64'(bus.rf_wr_en), 64'h0);
    check({tag, "_addr"},  64'(bus.rf_wr_addr), 64'h0);
    check({tag, "_data"},  64'(bus.rf_wr_data), 64'h0);
    check({tag, "_tag"},   64'(bus.instr_tag_out), 64'h0);
    check({tag, "_instr"}, 64'(bus.instr_out), 64'h0);
    check({tag, "_mask"},  64'(bus.pending_rd_mask), 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.src_valid = '0;
    bus.src_entry = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_mask [5];

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.src_valid = '0;
    bus.src_entry = '0;
    exp_mask[0] = 32'h3E;
    exp_mask[1] = 32'h3C;
    exp_mask[2] = 32'h38;
    exp_mask[3] = 32'h30;
    exp_mask[4] = 32'h20;

    // Reset state
    #12;
    check_idle("reset");
`ifdef WB_RETIRE_CNT_EN
    check("reset_retire", retire_cnt, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Lone ALU write, rd=5
    @(negedge clk);
    bus.src_valid[SRC_ALU] = 1'b1;
    bus.src_entry[SRC_ALU] = mk(32'h1234, 5'd5, 32'hAA, 32'hDEAD_BEEF);
    check("alu_pre_en", 64'(bus.rf_wr_en), 64'h0);
    @(negedge clk);
    bus.src_valid = '0;
    check("alu_en",    64'(bus.rf_wr_en), 64'h1);
    check("alu_addr",  64'(bus.rf_wr_addr), 64'd5);
    check("alu_data",  64'(bus.rf_wr_data), 64'h1234);
    check("alu_tag",   64'(bus.instr_tag_out), 64'hAA);
    check("alu_instr", 64'(bus.instr_out), 64'hDEAD_BEEF);
    check("alu_full",  64'(bus.src_full[SRC_ALU]), 64'h0);
    check("alu_mask",  64'(bus.pending_rd_mask), 64'h20);
    @(negedge clk);
    check("alu_after_en",   64'(bus.rf_wr_en), 64'h0);
    check("alu_after_mask", 64'(bus.pending_rd_mask), 64'h0);

    // All five sources at once, pointer freshly reset to 0
    do_reset();
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      bus.src_valid[i] = 1'b1;
      bus.src_entry[i] = mk(32'h100 + 32'(i), 5'(i + 1), 32'h10 + 32'(i), 32'h0);
    end
    for (int k = 0; k < WB_NUM_SRC; k++) begin
      @(negedge clk);
      bus.src_valid = '0;
      check($sformatf("all_en%0d", k),   64'(bus.rf_wr_en), 64'h1);
      check($sformatf("all_addr%0d", k), 64'(bus.rf_wr_addr), 64'(k + 1));
      check($sformatf("all_data%0d", k), 64'(bus.rf_wr_data), 64'(32'h100 + 32'(k)));
      check($sformatf("all_mask%0d", k), 64'(bus.pending_rd_mask), 64'(exp_mask[k]));
    end
    check("all_full_last", 64'(bus.src_full), 64'h0);
    @(negedge clk);
    check("all_done_en",   64'(bus.rf_wr_en), 64'h0);
    check("all_done_mask", 64'(bus.pending_rd_mask), 64'h0);

    // MUL with rd=0 is dropped entirely
    do_reset();
    bus.src_valid[SRC_MUL] = 1'b1;
    bus.src_entry[SRC_MUL] = mk(32'h5555, 5'd0, 32'h1, 32'h2);
    @(negedge clk);
    bus.src_valid = '0;
    check("rd0_en",   64'(bus.rf_wr_en), 64'h0);
    check("rd0_mask", 64'(bus.pending_rd_mask), 64'h0);
    check("rd0_full", 64'(bus.src_full), 64'h0);
`ifdef WB_RETIRE_CNT_EN
    check("rd0_retire", retire_cnt, 64'd0);
`endif
    @(negedge clk);
    check("rd0_en2", 64'(bus.rf_wr_en), 64'h0);

    // ALU and LSU request every cycle: grants alternate
    do_reset();
    bus.src_entry[SRC_ALU] = mk(32'hA, 5'd10, 32'h0, 32'h0);
    bus.src_entry[SRC_LSU] = mk(32'hB, 5'd20, 32'h0, 32'h0);
    bus.src_valid[SRC_ALU] = 1'b1;
    bus.src_valid[SRC_LSU] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k % 2 == 1) begin
        check($sformatf("rr_addr%0d", k), 64'(bus.rf_wr_addr), 64'd10);
        check($sformatf("rr_full%0d", k), 64'(bus.src_full), 64'b10000);
      end else begin
        check($sformatf("rr_addr%0d", k), 64'(bus.rf_wr_addr), 64'd20);
        check($sformatf("rr_full%0d", k), 64'(bus.src_full), 64'b00001);
      end
      check($sformatf("rr_mask%0d", k), 64'(bus.pending_rd_mask), 64'h0010_0400);
    end
    bus.src_valid = '0;

    // Three buffers full, then reset mid-operation
    do_reset();
    bus.src_valid = 5'b00111;
    bus.src_entry[SRC_ALU] = mk(32'h7, 5'd7, 32'h0, 32'h0);
    bus.src_entry[SRC_MUL] = mk(32'h8, 5'd8, 32'h0, 32'h0);
    bus.src_entry[SRC_DIV] = mk(32'h9, 5'd9, 32'h0, 32'h0);
    @(negedge clk);
    bus.src_valid = '0;
    check("rst_mid_mask", 64'(bus.pending_rd_mask), 64'h380);
    check("rst_mid_full", 64'(bus.src_full), 64'b00110);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_post_en%0d", k),   64'(bus.rf_wr_en), 64'h0);
      check($sformatf("rst_post_mask%0d", k), 64'(bus.pending_rd_mask), 64'h0);
    end

`ifdef WB_RETIRE_CNT_EN
    // Ten back-to-back writes
    do_reset();
    bus.src_entry[SRC_ALU] = mk(32'h1, 5'd1, 32'h0, 32'h0);
    bus.src_valid[SRC_ALU] = 1'b1;
    repeat (10) @(negedge clk);
    bus.src_valid = '0;
    @(negedge clk);
    check("retire_10", retire_cnt, 64'd10);

    // Wrap from all ones
    force dut.retire_q = '1;
    @(negedge clk);
    release dut.retire_q;
    check("retire_preload", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.src_valid[SRC_ALU] = 1'b1;
    @(negedge clk);
    bus.src_valid = '0;
    @(negedge clk);
    check("retire_wrap", retire_cnt, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have parameter NSRC, default WB_NUM_SRC (5), number of writeback sources; index 0=ALU, 1=MUL, 2=DIV, 3=MAC, 4=LSU.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port src_valid  input  NSRC  per-source writeback request, one-cycle pulse.
REQ-005 SHALL have port src_entry  input  NSRC x wb_entry_t  per-source {data XLEN, rd 5, tag XLEN, instr 32}.
REQ-006 SHALL have port src_full  output  NSRC  source buffer cannot accept next cycle (backpressure to unit).
REQ-007 SHALL have port rf_wr_en  output  1  register-file write strobe.
REQ-008 SHALL have port rf_wr_addr  output  5  destination register.
REQ-009 SHALL have port rf_wr_data  output  XLEN  write data.
REQ-010 SHALL have port instr_tag_out  output  XLEN  debug tag of retiring entry.
REQ-011 SHALL have port instr_out  output  32  debug instruction of retiring entry.
REQ-012 SHALL have port pending_rd_mask  output  32  bit r set while any buffer holds rd=r (hazard info to IDU1).
REQ-013 SHALL have port retire_cnt  output  64  retired-writeback count (present only per REQ-030).

Function
REQ-014 SHALL hold one single-entry buffer per source; buf_valid[i] and buf_entry[i] registered.
REQ-015 SHALL capture src_entry[i] at the clock edge when src_valid[i]=1 and src_full[i]=0.
REQ-016 SHALL discard captures with rd=0: no buffer load, no write, no count.
REQ-017 SHALL drive src_full[i] = buf_valid[i] & ~grant[i]; a source drained in cycle N may load a new entry at the same edge.
REQ-018 SHALL ignore src_valid[i] while src_full[i]=1 (protocol violation; buffer unchanged).
REQ-019 SHALL grant exactly one valid buffer per cycle via round-robin; priority pointer advances to (winner+1) mod NSRC after each grant, unchanged when no grant.
REQ-020 SHALL drive rf_wr_en/addr/data, instr_tag_out, instr_out combinationally from the granted buffer; all zero when no buffer valid.
REQ-021 SHALL clear buf_valid of the granted source at the next edge unless reloaded per REQ-017.
REQ-022 SHALL give latency exactly 1 cycle (capture edge to rf_wr_en) for a lone request; worst case NSRC cycles with all buffers full.
REQ-023 SHALL compute pending_rd_mask as the OR of one-hot(rd) over all valid buffers, including the one being granted this cycle.
REQ-024 SHALL NOT order same-rd entries across sources; IDU1 uses pending_rd_mask to prevent such issue.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear all buf_valid, set the round-robin pointer to 0, clear retire_cnt.
REQ-026 SHALL drive after reset: src_full=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, instr_tag_out=0, instr_out=0, pending_rd_mask=0.
REQ-027 SHALL drop buffered entries if reset asserts mid-operation; no write after rst_n deasserts until a new capture.

Configuration
REQ-028 SHALL compile the retire counter only when macro WB_RETIRE_CNT_EN is defined.
REQ-029 SHALL with WB_RETIRE_CNT_EN increment retire_cnt by 1 each cycle rf_wr_en=1, wrapping from 2^64-1 to 0.
REQ-030 SHALL without WB_RETIRE_CNT_EN omit the retire_cnt port and its register entirely.

Structure
REQ-031 SHALL place WB_NUM_SRC, source index constants and wb_entry_t in the shared types package.
REQ-032 SHALL implement grant selection in sub-module rr_arb (NSRC request in, one-hot grant out, pointer internal).

Verification
REQ-033 SHALL test lone ALU write rd=5, data 0x1234 -> rf_wr_en one cycle later, addr 5, data 0x1234, src_full[0]=0.
REQ-034 SHALL test all five sources valid same cycle, rd 1..5, pointer 0 -> writes rd 1,2,3,4,5 on consecutive cycles; pending_rd_mask 0x3E then shrinking to 0.
REQ-035 SHALL test MUL rd=0 request -> no rf_wr_en, pending_rd_mask stays 0, retire_cnt unchanged.
REQ-036 SHALL test ALU and LSU requesting every cycle -> grants alternate ALU/LSU, neither starved, src_full toggles correctly.
REQ-037 SHALL test three buffers full then rst_n low one cycle -> all outputs zero, no rf write after release.
REQ-038 SHALL test with WB_RETIRE_CNT_EN, 10 writes -> retire_cnt=10; preloaded 2^64-1 plus one write -> 0.
